// File: rtl/alu_lane_sequencer.sv
// alu_lane_sequencer: walks a packed vector operation through a single
// combinational scalar ALU one lane per cycle, collecting the lane results,
// a per-lane zero mask and OR/AND-reduced flags, then offers them as one
// response. Request and response ports are both valid/ready.
module alu_lane_sequencer #(
  parameter int N     = 32,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [LANES*N-1:0]   req_va,
  input  logic [LANES*N-1:0]   req_vb,
  input  logic                 req_bcast,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [3:0]           alu_control,
  input  logic [N-1:0]         alu_result,
  input  logic [3:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [LANES*N-1:0]   rsp_vr,
  output logic [LANES-1:0]     rsp_zmask,
  output logic [3:0]           rsp_flags
);

  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [IW-1:0]        idx_reg;
  logic [3:0]           op_reg;
  logic [LANES*N-1:0]   va_reg;
  logic [LANES*N-1:0]   vb_reg;
  logic [LANES*N-1:0]   vr_reg;
  logic [LANES-1:0]     zmask_reg;
  logic [3:0]           flags_reg;   // {N, Z, C, V}
  logic [LANES*N-1:0]   vb_eff;
  logic                 accept;

  // Broadcast replicates lane 0 of B into every lane before it is latched.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_bcast
    assign vb_eff[gi*N +: N] = req_bcast ? req_vb[N-1:0] : req_vb[gi*N +: N];
  end

  assign accept    = req_valid && req_ready;
  assign rsp_vr    = vr_reg;
  assign rsp_zmask = zmask_reg;
  assign rsp_flags = flags_reg;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and handshake/ALU-port outputs; ALU ports are idle-zero outside RUN.
  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 4'b0000;
    case (state_reg)
      IDLE: begin
        // Held low while reset is asserted so nothing is accepted mid-reset.
        req_ready = !reset;
        if (req_valid && !reset) state_next = RUN;
      end
      RUN: begin
        alu_a       = va_reg[idx_reg*N +: N];
        alu_b       = vb_reg[idx_reg*N +: N];
        alu_control = op_reg;
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch on accept, then one lane of result/flags captured per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg   <= '0;
      op_reg    <= 4'b0000;
      va_reg    <= '0;
      vb_reg    <= '0;
      vr_reg    <= '0;
      zmask_reg <= '0;
      flags_reg <= 4'b0000;
    end else if (accept) begin
      idx_reg   <= '0;
      op_reg    <= req_op;
      va_reg    <= req_va;
      vb_reg    <= vb_eff;
      vr_reg    <= '0;
      zmask_reg <= '0;
      flags_reg <= 4'b0100;  // Z is an AND-reduction, so it starts set
    end else if (state_reg == RUN) begin
      vr_reg[idx_reg*N +: N] <= alu_result;
      zmask_reg[idx_reg]     <= alu_flags[2];
      flags_reg <= {flags_reg[3] | alu_flags[3],
                    flags_reg[2] & alu_flags[2],
                    flags_reg[1] | alu_flags[1],
                    flags_reg[0] | alu_flags[0]};
      // Saturate at the last lane rather than wrap.
      if (idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Self-checking bench for alu_lane_sequencer with a small scalar ALU model
// attached to the ALU port.
module tb_alu_lane_sequencer;

  localparam int N     = 32;
  localparam int LANES = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid, req_ready;
  logic [3:0]         req_op;
  logic [127:0]       req_va, req_vb;
  logic               req_bcast;
  logic [31:0]        alu_a, alu_b, alu_result;
  logic [3:0]         alu_control, alu_flags;
  logic               rsp_valid, rsp_ready;
  logic [127:0]       rsp_vr;
  logic [3:0]         rsp_zmask, rsp_flags;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  alu_lane_sequencer #(.N(N), .LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_va(req_va), .req_vb(req_vb), .req_bcast(req_bcast),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_vr(rsp_vr), .rsp_zmask(rsp_zmask), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scalar ALU model: and/or/add/sub/sll; carry = unsigned borrow on sub;
  // overflow = signed overflow on add/sub; unknown opcodes give 0.
  always_comb begin
    logic [32:0] diff;
    alu_result = 32'd0;
    alu_flags  = 4'b0000;
    diff       = {1'b0, alu_a} - {1'b0, alu_b};
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: begin
        alu_result   = alu_a + alu_b;
        alu_flags[0] = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'b0110: begin
        alu_result   = diff[31:0];
        alu_flags[1] = diff[32];
        alu_flags[0] = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'b1010: alu_result = alu_a << alu_b[4:0];
      default: alu_result = 32'd0;
    endcase
    alu_flags[3] = alu_result[31];
    alu_flags[2] = (alu_result == 32'd0);
  end

  typedef struct {
    logic [3:0]   op;
    logic [127:0] va;
    logic [127:0] vb;
    logic         bcast;
    logic [127:0] vr;
    logic [3:0]   zm;
    logic [3:0]   fl;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one request at an IDLE negedge, leave the bench at a negedge in IDLE.
  task automatic run_vec(input vec_t v, input int id);
    int j;
    req_op = v.op; req_va = v.va; req_vb = v.vb; req_bcast = v.bcast;
    req_valid = 1'b1; rsp_ready = 1'b1;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // Scramble request fields: they must only be sampled at accept.
    req_valid = 1'b0; req_op = 4'b0001; req_bcast = ~v.bcast;
    req_va = {4{32'hDEADBEEF}}; req_vb = {4{32'h12345678}};
    check("alu_a_lane0", alu_a, v.va[31:0]);
    check("alu_control", alu_control, v.op);
    check("req_ready_busy", req_ready, 0);
    j = 0;
    while (!rsp_valid && j < 20) begin
      @(negedge clk);
      j++;
    end
    check("latency", j, 4);
    check("rsp_vr", rsp_vr, v.vr);
    check("rsp_zmask", rsp_zmask, v.zm);
    check("rsp_flags", rsp_flags, v.fl);
    @(negedge clk);
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
    check("vr_held", rsp_vr, v.vr);
    $display("vec %0d op=%b vr=%h zmask=%b flags=%b", id, v.op, rsp_vr, rsp_zmask, rsp_flags);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int acc [3];
    int sel [3];

    tbl[0] = '{op: 4'b0010, va: {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1},
               vb: {32'd1, 32'd3, 32'd2, 32'd1}, bcast: 1'b0,
               vr: {32'd0, 32'd6, 32'd4, 32'd2}, zm: 4'b1000, fl: 4'b0000};
    tbl[1] = '{op: 4'b0110, va: {32'd5, 32'd5, 32'd5, 32'd5},
               vb: {32'd7, 32'd8, 32'd9, 32'd5}, bcast: 1'b1,
               vr: 128'd0, zm: 4'b1111, fl: 4'b0100};
    tbl[2] = '{op: 4'b1010, va: {32'd3, 32'h80000000, 32'd2, 32'd1},
               vb: {32'd9, 32'd9, 32'd9, 32'd4}, bcast: 1'b1,
               vr: {32'h30, 32'h0, 32'h20, 32'h10}, zm: 4'b0100, fl: 4'b0000};
    tbl[3] = '{op: 4'b0110, va: {32'h80000000, 32'd0, 32'd3, 32'd10},
               vb: {32'd1, 32'd1, 32'd3, 32'd4}, bcast: 1'b0,
               vr: {32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd6}, zm: 4'b0010, fl: 4'b1011};
    tbl[4] = '{op: 4'b1111, va: {32'd7, 32'd6, 32'd5, 32'd4},
               vb: {32'd1, 32'd1, 32'd1, 32'd1}, bcast: 1'b0,
               vr: 128'd0, zm: 4'b1111, fl: 4'b0100};

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 4'b0; req_va = '0; req_vb = '0; req_bcast = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_vr", rsp_vr, 0);
    check("rst_zmask", rsp_zmask, 0);
    check("rst_flags", rsp_flags, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_ctl", alu_control, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);

    // Table-driven vectors
    for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

    // Backpressure: hold rsp_ready low for three cycles in DONE
    req_op = tbl[3].op; req_va = tbl[3].va; req_vb = tbl[3].vb; req_bcast = tbl[3].bcast;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    j = 0;
    while (!rsp_valid && j < 20) begin
      @(negedge clk);
      j++;
    end
    check("bp_latency", j, 4);
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_vr", rsp_vr, tbl[3].vr);
      check("bp_zmask", rsp_zmask, tbl[3].zm);
      check("bp_flags", rsp_flags, tbl[3].fl);
      @(negedge clk);
    end
    check("bp_valid_still", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", rsp_valid, 0);
    check("bp_idle_ready", req_ready, 1);
    $display("backpressure vr=%h flags=%b", rsp_vr, rsp_flags);

    // Reset after two lanes are captured
    req_op = tbl[3].op; req_va = tbl[3].va; req_vb = tbl[3].vb; req_bcast = tbl[3].bcast;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_partial_vr", rsp_vr[31:0], 32'd6);
    reset = 1'b1;
    #1;
    check("mid_rst_vr", rsp_vr, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_alu_a", alu_a, 0);
    @(negedge clk);
    reset = 1'b0;
    j = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) j++;
    end
    check("mid_no_rsp", j, 0);
    check("mid_ready_after", req_ready, 1);
    $display("reset mid-run aborted, vr=%h", rsp_vr);
    run_vec(tbl[3], 3);

    // Back-to-back: req_valid held high across three ops
    sel[0] = 0; sel[1] = 2; sel[2] = 3;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_op = tbl[sel[k]].op; req_va = tbl[sel[k]].va;
      req_vb = tbl[sel[k]].vb; req_bcast = tbl[sel[k]].bcast;
      req_valid = 1'b1;
      j = 0;
      while (!req_ready && j < 20) begin
        @(negedge clk);
        j++;
      end
      acc[k] = cyc;
      @(posedge clk);
      @(negedge clk);
      j = 0;
      while (!rsp_valid && j < 20) begin
        @(negedge clk);
        j++;
      end
      check("b2b_latency", j, 4);
      check("b2b_vr", rsp_vr, tbl[sel[k]].vr);
      check("b2b_flags", rsp_flags, tbl[sel[k]].fl);
      if (k > 0) check("b2b_spacing", acc[k] - acc[k-1], 6);
      $display("b2b op %0d accepted at cycle %0d vr=%h", k, acc[k], rsp_vr);
    end
    req_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_lane_sequencer.md
# alu_lane_sequencer

Multi-cycle SIMD initiator that drives the shared scalar ALU one lane at a time. It accepts a packed vector operation over a valid/ready request port and iterates the lanes through the ALU's combinational `a`/`b`/`alucontrol` → `result`/`flags` interface. It assembles the packed result vector and aggregate flags, then returns them over a valid/ready response port. It sits between the vector issue stage and the single ALU instance in the datapath.

## Interface
Parameters:
- `N`, 32: element width; must match the ALU's `N`.
- `LANES`, 4: elements per vector; ≥ 2.

Ports:
- `clk`, in, 1: single clock. Everything is registered on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `req_valid`, in, 1: request valid.
- `req_ready`, out, 1: request ready.
- `req_op`, in, 4: ALU opcode, passed unchanged to `alu_control`.
- `req_va`, in, LANES*N: operand A. Lane i is at `[i*N +: N]`.
- `req_vb`, in, LANES*N: operand B, same packing as `req_va`.
- `req_bcast`, in, 1: when 1, every lane uses `req_vb[N-1:0]` as its B operand.
- `alu_a`, out, N: ALU operand a.
- `alu_b`, out, N: ALU operand b.
- `alu_control`, out, 4: ALU opcode.
- `alu_result`, in, N: ALU result, combinational from `alu_a`/`alu_b`/`alu_control`.
- `alu_flags`, in, 4: ALU flags {neg, zero, carry, overflow}, combinational.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response ready.
- `rsp_vr`, out, LANES*N: packed result vector.
- `rsp_zmask`, out, LANES: bit i is `alu_flags[2]` captured for lane i.
- `rsp_flags`, out, 4: aggregate flags, defined under Operation.

## Operation
State machine with three states: IDLE, RUN, DONE.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `req_op`, `req_va`, and the effective B vector (`req_vb`, or its lane 0 replicated when `req_bcast`=1).
  - Clear the result vector, zmask and aggregate flags; set lane index = 0; go to RUN.
  - Request fields are sampled only at accept.
- **RUN**
  - `alu_a` and `alu_b` are lane `idx` of the latched operands; `alu_control` is the latched op. All three are combinational from registers.
  - Each edge, `rsp_vr` lane `idx` ← `alu_result` and `rsp_zmask[idx]` ← `alu_flags[2]`.
  - Aggregate flags update on each lane:
    - N |= `alu_flags[3]`
    - C |= `alu_flags[1]`
    - V |= `alu_flags[0]`
    - Z &= `alu_flags[2]` (Z starts at 1 on accept).
  - `idx` == LANES-1 → DONE; otherwise `idx`+1.
- **DONE**
  - `rsp_valid`=1; all `rsp_*` outputs are held stable.
  - On `rsp_ready`, go to IDLE.
- Outside RUN, `alu_a`, `alu_b` and `alu_control` are driven to 0.
- `rsp_vr`, `rsp_zmask` and `rsp_flags` keep their last values after the response handshake until the next accept clears them.
- Opcodes are not interpreted. Undefined opcodes pass through, and the ALU returns 0 for them.
- `idx` width is `$clog2(LANES)`. It never exceeds LANES-1 and never wraps.

## Timing
- **Accept to response:** accept at edge k; lanes captured at edges k+1 … k+LANES; `rsp_valid` high from edge k+LANES.
- **Fastest handshake:** if `rsp_ready`=1, the response handshake completes at edge k+LANES+1.
- **Throughput:** `req_ready` is high only in IDLE, so back-to-back ops are accepted every LANES+2 cycles (6 for LANES=4).
- **Backpressure:** while `rsp_valid`=1 and `rsp_ready`=0, the FSM stays in DONE, outputs are unchanged and `req_ready`=0.
- **Reset values, while `reset` is asserted:**
  - State = IDLE and `idx` = 0.
  - `req_ready`=0 (forced low during reset) and `rsp_valid`=0.
  - `rsp_vr`=0, `rsp_zmask`=0, `rsp_flags`=0.
  - `alu_a`, `alu_b` and `alu_control` = 0.
- **After reset:** `req_ready`=1 from the first cycle after `reset` deasserts.
- **Reset mid-operation:** aborts immediately. No response is produced and the partial results are discarded.
- **Zero-latency path:** the ALU is combinational, so a lane's result is valid in the same cycle its operands are driven. There is no other combinational path from inputs to outputs.

## Test plan
All scenarios use N=32, LANES=4.

1. **Add:** va={1,2,3,0xFFFFFFFF}, vb={1,2,3,1} (lanes 0..3), op=0010, `rsp_ready`=1 → `rsp_vr`={2,4,6,0}, `rsp_zmask`=4'b1000, `rsp_flags`=4'b0000. `rsp_valid` rises 4 edges after accept.
2. **Broadcast subtract:** va={5,5,5,5}, vb lane0=5, `req_bcast`=1, op=0110 → `rsp_vr` all 0, `rsp_zmask`=4'b1111, Z=1, `rsp_flags`=4'b0100.
3. **Shift with broadcast:** va={1,2,0x80000000,3}, vb lane0=4, `req_bcast`=1, op=1010 → `rsp_vr`={0x10,0x20,0,0x30}, `rsp_zmask`=4'b0100.
4. **Backpressure:** hold `rsp_ready`=0 for 3 cycles in DONE, then raise it → `rsp_vr`, `rsp_zmask` and `rsp_flags` are identical in every cycle, `req_ready`=0 throughout, and the FSM returns to IDLE on the edge where `rsp_ready` is sampled high.
5. **Reset mid-RUN:** assert `reset` after 2 lanes are captured → `rsp_vr`=0, `rsp_valid` never rises, `req_ready`=1 the cycle after release, and a new op then completes correctly.
6. **Back-to-back requests:** hold `req_valid`=1 with `rsp_ready`=1 for 3 ops → accepts are exactly 6 cycles apart, and each response matches its own operands.
